// File: rtl/nvio3_pkg.sv
// nvio3_pkg
//   Shared definitions for the link-register file and its write scheduler.
//   LK_AW / LK_DW / LK_NREG : address width, data width, register count.
//   lk_wreq_t               : one write-port transaction (valid, address, data).
//   lk_onehot()             : one-hot decode of a register address, gated by valid.
package nvio3_pkg;

  localparam int LK_AW   = 3;
  localparam int LK_DW   = 128;
  localparam int LK_NREG = 8;

  typedef struct packed {
    logic             v;
    logic [LK_AW-1:0] wa;
    logic [LK_DW-1:0] d;
  } lk_wreq_t;

  function automatic logic [LK_NREG-1:0] lk_onehot(input logic v, input logic [LK_AW-1:0] wa);
    return v ? (LK_NREG'(1) << wa) : '0;
  endfunction

endpackage

// File: rtl/lk_rr_pick2.sv
// lk_rr_pick2
//   Combinational round-robin picker for two write ports.
//   ptr      : current round-robin start index (0..NREQ-1)
//   valid    : per-requester request bits
//   addr     : per-requester target register, packed NREQ x AW
//   g0_v/g0_idx, g1_v/g1_idx : port-0 / port-1 grant and requester index
//   zr_ready : requesters targeting register 0 (accepted without a port)
//   ptr_next : start index for the next cycle, assuming the grants are taken
module lk_rr_pick2 #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int PW   = 2
) (
  input  logic [PW-1:0]      ptr,
  input  logic [NREQ-1:0]    valid,
  input  logic [NREQ*AW-1:0] addr,
  output logic               g0_v,
  output logic [PW-1:0]      g0_idx,
  output logic               g1_v,
  output logic [PW-1:0]      g1_idx,
  output logic [NREQ-1:0]    zr_ready,
  output logic [PW-1:0]      ptr_next
);

  logic [AW-1:0]   wa [NREQ];
  logic [NREQ-1:0] nz;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign wa[gi]       = addr[gi*AW +: AW];
    assign nz[gi]       = |wa[gi];
    assign zr_ready[gi] = valid[gi] & ~nz[gi];
  end

  always_comb begin
    logic [PW-1:0] idx;
    logic [AW-1:0] g0_wa;
    g0_v   = 1'b0;
    g0_idx = '0;
    g1_v   = 1'b0;
    g1_idx = '0;
    idx    = '0;
    g0_wa  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (valid[idx] && nz[idx]) begin
        if (!g0_v) begin
          g0_v   = 1'b1;
          g0_idx = idx;
          g0_wa  = wa[idx];
        end else if (!g1_v && (wa[idx] != g0_wa)) begin
          // A same-address requester is skipped, so a later one can still
          // take port 1 and the two ports never collide.
          g1_v   = 1'b1;
          g1_idx = idx;
        end
      end
    end
    if (g1_v) begin
      ptr_next = PW'((int'(g1_idx) + 1) % NREQ);
    end else if (g0_v) begin
      ptr_next = PW'((int'(g0_idx) + 1) % NREQ);
    end else begin
      ptr_next = ptr;
    end
  end

endmodule

// File: rtl/lk_wr_sched.sv
// lk_wr_sched
//   Write-port scheduler for the 8 x 128-bit link-register file. Grants up to
//   two nonzero-address requests per cycle, round-robin, onto two registered
//   write ports; register-0 writes are acknowledged and dropped.
//   clk, rst_n     : clock, asynchronous active-low reset
//   stall, flush   : suppress all grants this cycle (flush also wins over stall)
//   req/req_wa/req_d : per-requester request, target register, data
//   ready          : combinational per-requester acknowledge
//   wr0/wa0/i0, wr1/wa1/i1 : registered write ports to the file
//   pend           : one-hot map of registers written this cycle
//   wcnt           : running count of issued writes (wraps at 2^32)
//   AW/DW must equal the package LK_AW/LK_DW, since port state uses lk_wreq_t.
module lk_wr_sched
  import nvio3_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = LK_AW,
  parameter int DW   = LK_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_wa,
  input  logic [NREQ*DW-1:0] req_d,
  output logic [NREQ-1:0]    ready,
  output logic               wr0,
  output logic               wr1,
  output logic [AW-1:0]      wa0,
  output logic [AW-1:0]      wa1,
  output logic [DW-1:0]      i0,
  output logic [DW-1:0]      i1,
  output logic [LK_NREG-1:0] pend,
  output logic [31:0]        wcnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   ptr_next;
  logic            g0_v;
  logic            g1_v;
  logic [PW-1:0]   g0_idx;
  logic [PW-1:0]   g1_idx;
  logic [NREQ-1:0] zr_ready;
  logic            en;

  logic [AW-1:0]   wa_arr [NREQ];
  logic [DW-1:0]   d_arr  [NREQ];

  lk_wreq_t        port0_reg;
  lk_wreq_t        port1_reg;
  lk_wreq_t        port0_next;
  lk_wreq_t        port1_next;
  logic [31:0]     wcnt_reg;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign wa_arr[gi] = req_wa[gi*AW +: AW];
    assign d_arr[gi]  = req_d[gi*DW +: DW];
  end

  lk_rr_pick2 #(
    .NREQ(NREQ),
    .AW  (AW),
    .PW  (PW)
  ) u_pick (
    .ptr     (ptr_reg),
    .valid   (req),
    .addr    (req_wa),
    .g0_v    (g0_v),
    .g0_idx  (g0_idx),
    .g1_v    (g1_v),
    .g1_idx  (g1_idx),
    .zr_ready(zr_ready),
    .ptr_next(ptr_next)
  );

  // rst_n is folded in so nothing is acknowledged while reset is held.
  assign en = rst_n & ~stall & ~flush;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign ready[gi] = en & (zr_ready[gi]
                           | (g0_v && (g0_idx == PW'(gi)))
                           | (g1_v && (g1_idx == PW'(gi))));
  end

  always_comb begin
    port0_next.v  = en & g0_v;
    port0_next.wa = wa_arr[g0_idx];
    port0_next.d  = d_arr[g0_idx];
    port1_next.v  = en & g1_v;
    port1_next.wa = wa_arr[g1_idx];
    port1_next.d  = d_arr[g1_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= '0;
      port0_reg <= '0;
      port1_reg <= '0;
      wcnt_reg  <= '0;
    end else begin
      if (en) begin
        ptr_reg <= ptr_next;
      end
      port0_reg.v <= port0_next.v;
      port1_reg.v <= port1_next.v;
      // Address/data only move on a grant; idle ports keep their last values.
      if (port0_next.v) begin
        port0_reg.wa <= port0_next.wa;
        port0_reg.d  <= port0_next.d;
      end
      if (port1_next.v) begin
        port1_reg.wa <= port1_next.wa;
        port1_reg.d  <= port1_next.d;
      end
      wcnt_reg <= wcnt_reg + 32'(port0_next.v) + 32'(port1_next.v);
    end
  end

  assign wr0  = port0_reg.v;
  assign wa0  = port0_reg.wa;
  assign i0   = port0_reg.d;
  assign wr1  = port1_reg.v;
  assign wa1  = port1_reg.wa;
  assign i1   = port1_reg.d;
  assign wcnt = wcnt_reg;
  assign pend = (lk_onehot(wr0, wa0) | lk_onehot(wr1, wa1)) & ~LK_NREG'(1);

endmodule

// File: tb/tb_lk_wr_sched.sv
module tb_lk_wr_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall;
  logic         flush;
  logic [3:0]   req;
  logic [11:0]  req_wa;
  logic [511:0] req_d;
  logic [3:0]   ready;
  logic         wr0, wr1;
  logic [2:0]   wa0, wa1;
  logic [127:0] i0, i1;
  logic [7:0]   pend;
  logic [31:0]  wcnt;

  lk_wr_sched #(.NREQ(4), .AW(3), .DW(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .req   (req),
    .req_wa(req_wa),
    .req_d (req_d),
    .ready (ready),
    .wr0   (wr0),
    .wr1   (wr1),
    .wa0   (wa0),
    .wa1   (wa1),
    .i0    (i0),
    .i1    (i1),
    .pend  (pend),
    .wcnt  (wcnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         wr0;
    logic         wr1;
    logic [2:0]   wa0;
    logic [2:0]   wa1;
    logic [127:0] d0;
    logic [127:0] d1;
    logic [7:0]   pend;
    logic [31:0]  wcnt;
  } obs_t;

  obs_t         sb[$];
  int           n_checks = 0;
  int           n_pass = 0;
  logic [31:0]  exp_wcnt = 0;
  logic [2:0]   adr [4];
  logic [127:0] dat [4];
  obs_t         e, o;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester k targets register a with fresh random data.
  task automatic set_req(input int k, input logic [2:0] a);
    adr[k] = a;
    dat[k] = {$urandom, $urandom, $urandom, $urandom};
    req_wa[k*3 +: 3]   = a;
    req_d[k*128 +: 128] = dat[k];
  endtask

  // Expected port contents one cycle after the grant; stale wa/i are masked.
  task automatic push_exp(input logic v0, input int k0, input logic v1, input int k1);
    obs_t x;
    logic [7:0] pm;
    x = '0;
    pm = 8'd0;
    if (v0) begin
      x.wr0 = 1'b1; x.wa0 = adr[k0]; x.d0 = dat[k0];
      pm = pm | (8'd1 << adr[k0]);
    end
    if (v1) begin
      x.wr1 = 1'b1; x.wa1 = adr[k1]; x.d1 = dat[k1];
      pm = pm | (8'd1 << adr[k1]);
    end
    x.pend = pm;
    exp_wcnt = exp_wcnt + 32'(v0) + 32'(v1);
    x.wcnt = exp_wcnt;
    sb.push_back(x);
  endtask

  function automatic obs_t observe();
    obs_t x;
    x.wr0  = wr0;
    x.wr1  = wr1;
    x.wa0  = wr0 ? wa0 : 3'd0;
    x.wa1  = wr1 ? wa1 : 3'd0;
    x.d0   = wr0 ? i0 : 128'd0;
    x.d1   = wr1 ? i1 : 128'd0;
    x.pend = pend;
    x.wcnt = wcnt;
    return x;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; req = 4'b0000;
    req_wa = '0; req_d = '0;
    set_req(0, 3'd1); set_req(1, 3'd2); set_req(2, 3'd3); set_req(3, 3'd4);
    #2;
    rst_n = 1'b0;
    req = 4'b1111;
    #1;
    n_checks++;
    o = observe();
    if (o !== obs_t'(0) || {wa0, wa1, i0, i1} !== '0)
      $display("FAIL reset_async got=%h want=0 raw_wa=%h/%h", o, wa0, wa1);
    else n_pass++;
    n_checks++;
    if (ready !== 4'b0000) $display("FAIL reset_ready got=%b want=0000", ready);
    else n_pass++;
    tick();
    n_checks++;
    o = observe();
    if (o !== obs_t'(0)) $display("FAIL reset_held got=%h want=0", o);
    else n_pass++;
    rst_n = 1'b1;
    req = 4'b0000;
    #1;
    n_checks++;
    if (wcnt !== 32'd0) $display("FAIL reset_wcnt got=%0d want=0", wcnt);
    else n_pass++;
    push_exp(1'b0, 0, 1'b0, 0);
    tick();
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL reset_idle got=%h want=%h", o, e);
    else n_pass++;
  endtask

  task automatic test_two_distinct();
    set_req(0, 3'd3); set_req(1, 3'd5);
    req = 4'b0011;
    #1;
    n_checks++;
    if (ready !== 4'b0011) $display("FAIL distinct_ready got=%b want=0011", ready);
    else n_pass++;
    push_exp(1'b1, 0, 1'b1, 1);
    tick();
    req = 4'b0000;
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL distinct_out got=%h want=%h", o, e);
    else n_pass++;
    n_checks++;
    if (pend !== 8'b0010_1000 || wcnt !== 32'd2)
      $display("FAIL distinct_pend got=%b/%0d want=00101000/2", pend, wcnt);
    else n_pass++;
    push_exp(1'b0, 0, 1'b0, 0);
    tick();
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL distinct_idle got=%h want=%h", o, e);
    else n_pass++;
  endtask

  // Pointer is 2 here, so the scan reaches requester 0 before requester 1.
  task automatic test_collision();
    set_req(0, 3'd4); set_req(1, 3'd4);
    req = 4'b0011;
    #1;
    n_checks++;
    if (ready !== 4'b0001) $display("FAIL collide_ready got=%b want=0001", ready);
    else n_pass++;
    push_exp(1'b1, 0, 1'b0, 0);
    tick();
    req = 4'b0010;
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL collide_out0 got=%h want=%h", o, e);
    else n_pass++;
    #1;
    n_checks++;
    if (ready !== 4'b0010) $display("FAIL collide_ready2 got=%b want=0010", ready);
    else n_pass++;
    push_exp(1'b1, 1, 1'b0, 0);
    tick();
    req = 4'b0000;
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL collide_out1 got=%h want=%h", o, e);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    set_req(0, 3'd0); set_req(2, 3'd6);
    req = 4'b0101;
    #1;
    n_checks++;
    if (ready !== 4'b0101) $display("FAIL zero_ready got=%b want=0101", ready);
    else n_pass++;
    push_exp(1'b1, 2, 1'b0, 0);
    tick();
    req = 4'b0000;
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL zero_out got=%h want=%h", o, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    logic [3:0]  want;
    // Single grant from requester 3 brings the pointer back to 0.
    set_req(3, 3'd7);
    req = 4'b1000;
    #1;
    n_checks++;
    if (ready !== 4'b1000) $display("FAIL b2b_align_ready got=%b want=1000", ready);
    else n_pass++;
    push_exp(1'b1, 3, 1'b0, 0);
    tick();
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL b2b_align_out got=%h want=%h", o, e);
    else n_pass++;
    base = exp_wcnt;
    set_req(0, 3'd1); set_req(1, 3'd2); set_req(2, 3'd3); set_req(3, 3'd4);
    req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      want = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      #1;
      n_checks++;
      if (ready !== want) $display("FAIL b2b_ready c%0d got=%b want=%b", c, ready, want);
      else n_pass++;
      if (c % 2 == 0) push_exp(1'b1, 0, 1'b1, 1);
      else push_exp(1'b1, 2, 1'b1, 3);
      tick();
      n_checks++;
      e = sb.pop_front(); o = observe();
      if (o !== e) $display("FAIL b2b_out c%0d got=%h want=%h", c, o, e);
      else n_pass++;
      if (c % 2 == 0) begin set_req(0, 3'd1); set_req(1, 3'd2); end
      else begin set_req(2, 3'd3); set_req(3, 3'd4); end
    end
    n_checks++;
    if (wcnt - base !== 32'd8) $display("FAIL b2b_wcnt got=%0d want=8", wcnt - base);
    else n_pass++;
  endtask

  // Enters with pointer 0 and all four requesters still asserting.
  task automatic test_stall_flush();
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (ready !== 4'b0000) $display("FAIL stall_ready c%0d got=%b want=0000", c, ready);
      else n_pass++;
      push_exp(1'b0, 0, 1'b0, 0);
      tick();
      n_checks++;
      e = sb.pop_front(); o = observe();
      if (o !== e) $display("FAIL stall_out c%0d got=%h want=%h", c, o, e);
      else n_pass++;
    end
    stall = 1'b0;
    #1;
    n_checks++;
    if (ready !== 4'b0011) $display("FAIL stall_release_ready got=%b want=0011", ready);
    else n_pass++;
    push_exp(1'b1, 0, 1'b1, 1);
    tick();
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL stall_release_out got=%h want=%h", o, e);
    else n_pass++;
    set_req(0, 3'd1); set_req(1, 3'd2);
    flush = 1'b1;
    #1;
    n_checks++;
    if (ready !== 4'b0000) $display("FAIL flush_ready got=%b want=0000", ready);
    else n_pass++;
    push_exp(1'b0, 0, 1'b0, 0);
    tick();
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL flush_out got=%h want=%h", o, e);
    else n_pass++;
    flush = 1'b0;
    #1;
    n_checks++;
    if (ready !== 4'b1100) $display("FAIL flush_release_ready got=%b want=1100", ready);
    else n_pass++;
    push_exp(1'b1, 2, 1'b1, 3);
    tick();
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL flush_release_out got=%h want=%h", o, e);
    else n_pass++;
    set_req(2, 3'd3); set_req(3, 3'd4);
    stall = 1'b1; flush = 1'b1;
    #1;
    n_checks++;
    if (ready !== 4'b0000) $display("FAIL stallflush_ready got=%b want=0000", ready);
    else n_pass++;
    push_exp(1'b0, 0, 1'b0, 0);
    tick();
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL stallflush_out got=%h want=%h", o, e);
    else n_pass++;
    stall = 1'b0; flush = 1'b0;
    #1;
    n_checks++;
    if (ready !== 4'b0011) $display("FAIL stallflush_release_ready got=%b want=0011", ready);
    else n_pass++;
    push_exp(1'b1, 0, 1'b1, 1);
    tick();
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL stallflush_release_out got=%h want=%h", o, e);
    else n_pass++;
    set_req(0, 3'd1); set_req(1, 3'd2);
  endtask

  // Pointer is 2 on entry; reset lands while both ports are writing.
  task automatic test_reset_mid();
    #1;
    n_checks++;
    if (ready !== 4'b1100) $display("FAIL rstmid_pre_ready got=%b want=1100", ready);
    else n_pass++;
    push_exp(1'b1, 2, 1'b1, 3);
    tick();
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL rstmid_pre_out got=%h want=%h", o, e);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    o = observe();
    if (o !== obs_t'(0) || {wa0, wa1, i0, i1} !== '0 || ready !== 4'b0000)
      $display("FAIL rstmid_async got=%h ready=%b want=0/0000", o, ready);
    else n_pass++;
    exp_wcnt = 32'd0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ready !== 4'b0011) $display("FAIL rstmid_post_ready got=%b want=0011", ready);
    else n_pass++;
    push_exp(1'b1, 0, 1'b1, 1);
    tick();
    req = 4'b0000;
    n_checks++;
    e = sb.pop_front(); o = observe();
    if (o !== e) $display("FAIL rstmid_post_out got=%h want=%h", o, e);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_two_distinct();
    test_collision();
    test_zero_reg();
    test_back_to_back();
    test_stall_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
